// File: rtl/ntr_pkg.sv
// Shared constants and state encoding for the NTR word feeder.
package ntr_pkg;
    localparam logic [31:0] NTR_OPEN_BUS   = 32'hFFFF_FFFF;
    localparam int          NTR_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/ntr_word_feed_if.sv
// Memory read port between the word feeder (master) and the memory (slave).
interface ntr_word_feed_if #(
    parameter int ADDR_W = 24
);
    // mem_rd is a one-cycle request strobe with mem_addr valid alongside it;
    // every strobe earns exactly one mem_rvalid cycle, at least one cycle later,
    // in issue order, with no back-pressure in either direction.
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              mem_rvalid;

    modport master (output mem_rd, output mem_addr, input mem_rdata, input mem_rvalid);
    modport slave  (input mem_rd, input mem_addr, output mem_rdata, output mem_rvalid);
endinterface

// File: rtl/ntr_word_fifo.sv
// Small power-of-two FIFO of 32-bit words with occupancy count and flush.
module ntr_word_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [31:0]              wdata,
    input  logic                     pop,
    output logic [31:0]              rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PW + 1)'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty && !flush;
        // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
        do_push  = push && !flush && (!full || do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PW'(1);
                count_d         = count_d + (PW + 1)'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                count_d  = count_d - (PW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/ntr_word_feed.sv
// Prefetches a run of words from memory into a FIFO and feeds the head word to
// the NTR byte responder, showing open-bus when nothing is buffered.
module ntr_word_feed
    import ntr_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int WC_W   = 12,
    parameter int DEPTH  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [WC_W-1:0]    word_count,
    input  logic               request,
    output logic [31:0]        data,
    output logic               data_valid,
    output logic               done,
    output logic               underrun,
    output logic               busy,
    output state_t             dbg_state,
    ntr_word_feed_if.master    mem
);
    localparam int CW = $clog2(DEPTH) + 1;
    // One extra bit so discard can hold its 2*DEPTH ceiling.
    localparam int DW = CW + 1;
    localparam logic [DW:0] DISC_MAX = (DW + 1)'(2 * DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WC_W-1:0]   to_issue_q, to_issue_d;
    logic [WC_W-1:0]   to_consume_q, to_consume_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [DW-1:0]     discard_q, discard_d;
    logic              underrun_q, underrun_d;
    logic              done_q, done_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DW:0]       disc_sum;

    logic [31:0]       fifo_rdata;
    logic              fifo_empty, fifo_full;
    logic [CW-1:0]     fifo_count;
    logic              push, drop, pop, room;
    logic [ADDR_W-1:0] start_addr;

    assign start_addr = {base_addr[ADDR_W-1:2], 2'b00};
    assign push       = mem.mem_rvalid && (discard_q == '0) && (outstanding_q != '0) && !fifo_full;
    assign drop       = mem.mem_rvalid && (discard_q != '0);
    assign pop        = request && !fifo_empty;
    assign room       = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < (CW + 1)'(DEPTH);

    ntr_word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .push  (push),
        .wdata (mem.mem_rdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        to_issue_d    = to_issue_q;
        to_consume_d  = to_consume_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        underrun_d    = underrun_q;
        done_d        = 1'b0;
        mem_rd_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        disc_sum      = '0;

        if (push) outstanding_d = outstanding_q - CW'(1);
        if (drop) discard_d = discard_q - DW'(1);

        if (abort) begin
            // Reads still in flight become stale; their responses must be dropped.
            state_d       = IDLE;
            disc_sum      = {1'b0, discard_d} + (DW + 1)'(outstanding_d);
            discard_d     = (disc_sum > DISC_MAX) ? DISC_MAX[DW-1:0] : disc_sum[DW-1:0];
            outstanding_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        underrun_d   = 1'b0;
                        to_consume_d = word_count;
                        to_issue_d   = word_count;
                        addr_d       = start_addr;
                        if (word_count == '0) begin
                            done_d = 1'b1;
                        end else begin
                            // The first read goes out on the start edge itself.
                            mem_rd_d      = 1'b1;
                            mem_addr_d    = start_addr;
                            addr_d        = start_addr + ADDR_W'(NTR_WORD_BYTES);
                            to_issue_d    = word_count - WC_W'(1);
                            outstanding_d = outstanding_d + CW'(1);
                            state_d       = (word_count == WC_W'(1)) ? DRAIN : FETCH;
                        end
                    end
                end
                FETCH, DRAIN: begin
                    if (state_q == FETCH && room && to_issue_q != '0) begin
                        mem_rd_d      = 1'b1;
                        mem_addr_d    = addr_q;
                        addr_d        = addr_q + ADDR_W'(NTR_WORD_BYTES);
                        to_issue_d    = to_issue_q - WC_W'(1);
                        outstanding_d = outstanding_d + CW'(1);
                        if (to_issue_q == WC_W'(1)) state_d = DRAIN;
                    end
                    if (request && fifo_empty) underrun_d = 1'b1;
                    if (pop) begin
                        to_consume_d = to_consume_q - WC_W'(1);
                        if (to_consume_q == WC_W'(1)) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            to_issue_q    <= '0;
            to_consume_q  <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            underrun_q    <= 1'b0;
            done_q        <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            to_issue_q    <= to_issue_d;
            to_consume_q  <= to_consume_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            underrun_q    <= underrun_d;
            done_q        <= done_d;
            mem_rd_q      <= mem_rd_d;
            mem_addr_q    <= mem_addr_d;
        end
    end

    assign data         = fifo_empty ? NTR_OPEN_BUS : fifo_rdata;
    assign data_valid   = !fifo_empty;
    assign done         = done_q;
    assign underrun     = underrun_q;
    assign busy         = (state_q != IDLE);
    assign dbg_state    = state_q;
    assign mem.mem_rd   = mem_rd_q;
    assign mem.mem_addr = mem_addr_q;
endmodule

// File: tb/tb_ntr_word_feed.sv
// Bench for ntr_word_feed: latency-configurable memory model, per-scenario tasks, word/address scoreboard.
module tb_ntr_word_feed;
    import ntr_pkg::*;

    localparam int ADDR_W = 24;
    localparam int WC_W   = 12;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start, abort, request;
    logic [ADDR_W-1:0] base_addr;
    logic [WC_W-1:0]   word_count;
    logic [31:0]       data;
    logic              data_valid, done, underrun, busy;
    state_t            dbg_state;

    ntr_word_feed_if #(.ADDR_W(ADDR_W)) mem_if ();

    ntr_word_feed #(.ADDR_W(ADDR_W), .WC_W(WC_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .word_count (word_count),
        .request    (request),
        .data       (data),
        .data_valid (data_valid),
        .done       (done),
        .underrun   (underrun),
        .busy       (busy),
        .dbg_state  (dbg_state),
        .mem        (mem_if.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- memory model ----------------
    int                mem_lat_min = 1;
    int                mem_lat_max = 1;
    int                mcyc = 0;
    int                last_due = 0;
    logic [ADDR_W-1:0] mreq_q[$];
    int                mdue_q[$];

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a[15:0], ~a[23:8]} ^ 32'h3C5A_96E1;
    endfunction

    always @(negedge clk) begin
        int due;
        mcyc++;
        if (rst) begin
            mreq_q.delete();
            mdue_q.delete();
            mem_if.mem_rvalid = 1'b0;
            mem_if.mem_rdata  = '0;
        end else begin
            if (mem_if.mem_rd) begin
                due = mcyc + int'($urandom_range(mem_lat_max, mem_lat_min));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mreq_q.push_back(mem_if.mem_addr);
                mdue_q.push_back(due);
            end
            if (mdue_q.size() > 0 && mdue_q[0] <= mcyc) begin
                mem_if.mem_rvalid = 1'b1;
                mem_if.mem_rdata  = mem_word(mreq_q.pop_front());
                void'(mdue_q.pop_front());
            end else begin
                mem_if.mem_rvalid = 1'b0;
                mem_if.mem_rdata  = $urandom;
            end
        end
    end

    // ---------------- scoreboard / transfer driver ----------------
    logic [31:0]       exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    int done_cnt, done_k, last_pop_k, n_rd, n_open_bad, n_over, saw_busy;

    // Called at a falling edge; drives start immediately, then runs the transfer to completion.
    task automatic run_xfer(input logic [ADDR_W-1:0] base, input int cnt, input int mode, input int restart_k);
        logic [ADDR_W-1:0] a0, ai;
        logic [31:0]       e;
        int                pops;
        a0 = base - (base % 4);
        exp_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i < cnt; i++) begin
            ai = a0 + ADDR_W'(4 * i);
            exp_addr_q.push_back(ai);
            exp_q.push_back(mem_word(ai));
        end
        done_cnt = 0; done_k = -1; last_pop_k = -1; n_rd = 0;
        n_open_bad = 0; n_over = 0; saw_busy = 0; pops = 0;
        start = 1'b1; abort = 1'b0; base_addr = base; word_count = WC_W'(cnt); request = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            start = (k == restart_k);
            if (start) begin
                base_addr  = ~base;
                word_count = WC_W'(1);
            end
            if (mem_if.mem_rd) begin
                n_rd++;
                checks++;
                if (exp_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_addr: unexpected read at %h, expected no read", mem_if.mem_addr);
                end else begin
                    ai = exp_addr_q.pop_front();
                    if (mem_if.mem_addr !== ai) begin
                        errors++;
                        $display("FAIL mem_addr: got %h, expected %h", mem_if.mem_addr, ai);
                    end
                end
            end
            if (n_rd - pops > DEPTH) n_over++;
            if (done) begin
                done_cnt++;
                done_k = k;
            end
            if (busy) saw_busy = 1;
            if (!data_valid && data !== 32'hFFFF_FFFF) n_open_bad++;
            case (mode)
                0:       request = (k % 4 == 0);
                1:       request = 1'b1;
                2:       request = 1'($urandom_range(1, 0));
                default: request = (k > 12);
            endcase
            if (request && data_valid) begin
                pops++;
                last_pop_k = k;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL data: extra word %h, expected none", data);
                end else begin
                    e = exp_q.pop_front();
                    if (data !== e) begin
                        errors++;
                        $display("FAIL data: got %h, expected %h", data, e);
                    end
                end
            end
            if (done_k > 0 && k >= done_k + 3) break;
        end
        request = 1'b0;
        start   = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL words_missing: got %0d undelivered, expected 0", exp_q.size());
        end
        checks++;
        if (exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL reads_missing: got %0d unissued, expected 0", exp_addr_q.size());
        end
        checks++;
        if (n_over != 0) begin
            errors++;
            $display("FAIL in_flight: got %0d cycles above %0d, expected 0", n_over, DEPTH);
        end
        checks++;
        if (n_open_bad != 0) begin
            errors++;
            $display("FAIL open_bus: got %0d empty cycles without FFFFFFFF, expected 0", n_open_bad);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; request = 1'b0;
        base_addr = '0; word_count = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({data_valid, done, underrun, busy, mem_if.mem_rd} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 00000", {data_valid, done, underrun, busy, mem_if.mem_rd});
        end
        checks++;
        if (data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL reset_data: got %h, expected ffffffff", data);
        end
        checks++;
        if (mem_if.mem_addr !== '0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_addr_state: got %h/%0d, expected 0/0", mem_if.mem_addr, dbg_state);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        mem_lat_min = 1; mem_lat_max = 1;
        @(negedge clk);
        run_xfer(24'h000100, 3, 0, 0);
        checks++;
        if (done_cnt !== 1 || done_k !== last_pop_k + 1) begin
            errors++;
            $display("FAIL basic_done: got count %0d at %0d, expected 1 at %0d", done_cnt, done_k, last_pop_k + 1);
        end
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL basic_underrun: got %b, expected 0", underrun);
        end
    endtask

    task automatic test_underrun();
        mem_lat_min = 6; mem_lat_max = 6;
        @(negedge clk);
        run_xfer(24'h000040, 4, 0, 0);
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_flag: got %b, expected 1", underrun);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL underrun_done: got %0d pulses, expected 1", done_cnt);
        end
    endtask

    task automatic test_zero_length();
        @(negedge clk);
        run_xfer(24'h000800, 0, 1, 0);
        checks++;
        if (done_cnt !== 1 || done_k !== 1) begin
            errors++;
            $display("FAIL zero_done: got count %0d at %0d, expected 1 at 1", done_cnt, done_k);
        end
        checks++;
        if (saw_busy !== 0 || n_rd !== 0) begin
            errors++;
            $display("FAIL zero_idle: got busy %0d reads %0d, expected 0 0", saw_busy, n_rd);
        end
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL zero_underrun_clear: got %b, expected 0", underrun);
        end
    endtask

    task automatic test_start_ignored();
        mem_lat_min = 2; mem_lat_max = 2;
        @(negedge clk);
        run_xfer(24'h000400, 3, 1, 2);
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL restart_done: got %0d pulses, expected 1", done_cnt);
        end
    endtask

    task automatic test_full_hold();
        for (int it = 0; it < 2; it++) begin
            mem_lat_min = 1; mem_lat_max = (it == 0) ? 1 : 4;
            @(negedge clk);
            run_xfer(24'h000500 + ADDR_W'(it * 64), 8, 3, 0);
            checks++;
            if (done_cnt !== 1 || done_k !== last_pop_k + 1) begin
                errors++;
                $display("FAIL hold_done: got count %0d at %0d, expected 1 at %0d", done_cnt, done_k, last_pop_k + 1);
            end
        end
    endtask

    task automatic test_abort();
        mem_lat_min = 6; mem_lat_max = 6;
        @(negedge clk);
        start = 1'b1; base_addr = 24'h000300; word_count = WC_W'(4); request = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy %b done %b valid %b, expected 0 0 0", busy, done, data_valid);
        end
        run_xfer(24'h000200, 1, 1, 0);
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL abort_restart_done: got %0d pulses, expected 1", done_cnt);
        end
    endtask

    task automatic test_wrap();
        mem_lat_min = 2; mem_lat_max = 2;
        @(negedge clk);
        run_xfer(24'hFFFFFC, 2, 1, 0);
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL wrap_done: got %0d pulses, expected 1", done_cnt);
        end
        @(negedge clk);
        run_xfer(24'h000103, 1, 1, 0);
        checks++;
        if (n_rd !== 1) begin
            errors++;
            $display("FAIL unaligned_reads: got %0d, expected 1", n_rd);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            mem_lat_min = 1;
            mem_lat_max = int'($urandom_range(8, 1));
            @(negedge clk);
            run_xfer(ADDR_W'($urandom), int'($urandom_range(12, 1)), 2, 0);
            checks++;
            if (done_cnt !== 1 || done_k !== last_pop_k + 1) begin
                errors++;
                $display("FAIL random_done: got count %0d at %0d, expected 1 at %0d", done_cnt, done_k, last_pop_k + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        mem_lat_min = 3; mem_lat_max = 3;
        @(negedge clk);
        start = 1'b1; base_addr = 24'h000700; word_count = WC_W'(5); request = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || data_valid !== 1'b0 || data !== 32'hFFFF_FFFF || mem_if.mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got busy %b valid %b data %h rd %b, expected 0 0 ffffffff 0",
                     busy, data_valid, data, mem_if.mem_rd);
        end
        rst = 1'b0;
        @(negedge clk);
        run_xfer(24'h000600, 2, 1, 0);
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL reset_recover_done: got %0d pulses, expected 1", done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_zero_length();
        test_start_ignored();
        test_full_hold();
        test_abort();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
